// File: rtl/lfsr_pkg.sv
// Shared definitions for the LFSR random source: maximal-length Galois
// tap masks, draw FSM states and the rejection-sampling mask helper.
package lfsr_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DRAW,
    DONE
  } rng_state_e;

  // Right-shift Galois tap masks giving period 2^w-1, for w = 3..32.
  function automatic logic [31:0] taps(input int unsigned w);
    case (w)
      3:       return 32'h0000_0006;
      4:       return 32'h0000_000C;
      5:       return 32'h0000_0014;
      6:       return 32'h0000_0030;
      7:       return 32'h0000_0060;
      8:       return 32'h0000_00B8;
      9:       return 32'h0000_0110;
      10:      return 32'h0000_0240;
      11:      return 32'h0000_0500;
      12:      return 32'h0000_0829;
      13:      return 32'h0000_100D;
      14:      return 32'h0000_2015;
      15:      return 32'h0000_6000;
      16:      return 32'h0000_B400;
      17:      return 32'h0001_2000;
      18:      return 32'h0002_0400;
      19:      return 32'h0004_0023;
      20:      return 32'h0009_0000;
      21:      return 32'h0014_0000;
      22:      return 32'h0030_0000;
      23:      return 32'h0042_0000;
      24:      return 32'h00E1_0000;
      25:      return 32'h0120_0000;
      26:      return 32'h0200_0023;
      27:      return 32'h0400_0013;
      28:      return 32'h0900_0000;
      29:      return 32'h1400_0000;
      30:      return 32'h2000_0029;
      31:      return 32'h4800_0000;
      32:      return 32'h8020_0003;
      default: return 32'h0000_0000;
    endcase
  endfunction

  // Smallest 2^k-1 covering lim-1; lim==0 means the full range.
  function automatic logic [31:0] mask_for(input logic [31:0] lim);
    logic [31:0] m;
    if (lim == '0) return '1;
    m = lim - 32'd1;
    for (int unsigned i = 1; i < 32; i = i * 2) begin
      m = m | (m >> i);
    end
    return m;
  endfunction

endpackage

// File: rtl/lfsr_core.sv
// Galois right-shift LFSR state register with seed load and step enable.
// A zero seed is replaced by DEFAULT_SEED so the state never locks up.
module lfsr_core
  import lfsr_pkg::*;
#(
  parameter int unsigned      WIDTH        = 16,
  parameter logic [WIDTH-1:0] DEFAULT_SEED = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             step_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] seed_i,
  output logic [WIDTH-1:0] state_o
);

  localparam logic [WIDTH-1:0] TAPS = WIDTH'(taps(WIDTH));

  logic [WIDTH-1:0] state_q, state_d;

  // Next state: load wins over step.
  always_comb begin
    state_d = state_q;
    if (load_i) begin
      state_d = (seed_i == '0) ? DEFAULT_SEED : seed_i;
    end else if (step_i) begin
      state_d = (state_q >> 1) ^ (state_q[0] ? TAPS : '0);
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= DEFAULT_SEED;
    else        state_q <= state_d;
  end

  assign state_o = state_q;

endmodule

// File: rtl/lfsr_rng.sv
// Uniform random draws in [0, limit) from a Galois LFSR using masked
// rejection sampling with a bounded fallback after MAX_TRIES candidates.
// Optional: define RNG_STATS_EN to add the reject_cnt_o statistics output.
module lfsr_rng
  import lfsr_pkg::*;
#(
  parameter int unsigned WIDTH        = 16,
  parameter int unsigned OUT_W        = 8,
  parameter int unsigned MAX_TRIES    = 4,
  parameter int unsigned DEFAULT_SEED = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_i,
  input  logic             seed_load_i,
  input  logic [WIDTH-1:0] seed_i,
  input  logic             req_i,
  input  logic [OUT_W-1:0] limit_i,
  output logic             busy_o,
  output logic             rand_valid_o,
  output logic [OUT_W-1:0] rand_o
`ifdef RNG_STATS_EN
  ,
  output logic [15:0]      reject_cnt_o
`endif
);

  localparam int unsigned TW = $clog2(MAX_TRIES + 1);

  rng_state_e       state_q, state_d;
  logic [OUT_W-1:0] lim_q, lim_d;
  logic [OUT_W-1:0] mask_q, mask_d;
  logic [TW-1:0]    tries_q, tries_d;
  logic [OUT_W-1:0] rand_q, rand_d;
  logic [WIDTH-1:0] lfsr;
  logic [OUT_W-1:0] cand;
  logic             step;
  logic             reject;

  assign step = en_i || (state_q == DRAW);

  lfsr_core #(
    .WIDTH        (WIDTH),
    .DEFAULT_SEED (WIDTH'(DEFAULT_SEED))
  ) u_core (
    .clk     (clk),
    .rst_n   (rst_n),
    .step_i  (step),
    .load_i  (seed_load_i),
    .seed_i  (seed_i),
    .state_o (lfsr)
  );

  // Candidate comes from the pre-step LFSR state.
  assign cand = lfsr[OUT_W-1:0] & mask_q;

  // Draw FSM: seed_load aborts any draw; req only honoured in IDLE.
  always_comb begin
    state_d = state_q;
    lim_d   = lim_q;
    mask_d  = mask_q;
    tries_d = tries_q;
    rand_d  = rand_q;
    reject  = 1'b0;
    if (seed_load_i) begin
      state_d = IDLE;
      tries_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_i) begin
            state_d = DRAW;
            lim_d   = limit_i;
            mask_d  = OUT_W'(mask_for(32'(limit_i)));
            tries_d = '0;
          end
        end
        DRAW: begin
          tries_d = tries_q + TW'(1);
          if ((lim_q == '0) || (cand < lim_q)) begin
            rand_d  = cand;
            state_d = DONE;
          end else begin
            reject = 1'b1;
            // cand <= mask < 2*lim_q, so cand - lim_q lands in range.
            if (tries_q == TW'(MAX_TRIES - 1)) begin
              rand_d  = cand - lim_q;
              state_d = DONE;
            end
          end
        end
        DONE: begin
          state_d = IDLE;
          tries_d = '0;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // FSM and draw registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      lim_q   <= '0;
      mask_q  <= '0;
      tries_q <= '0;
      rand_q  <= '0;
    end else begin
      state_q <= state_d;
      lim_q   <= lim_d;
      mask_q  <= mask_d;
      tries_q <= tries_d;
      rand_q  <= rand_d;
    end
  end

  assign busy_o       = (state_q == DRAW);
  assign rand_valid_o = (state_q == DONE);
  assign rand_o       = rand_q;

`ifdef RNG_STATS_EN
  logic [15:0] reject_cnt_q;

  // Saturating count of rejected candidates, fallbacks included.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                          reject_cnt_q <= '0;
    else if (seed_load_i)                reject_cnt_q <= '0;
    else if (reject && reject_cnt_q != '1) reject_cnt_q <= reject_cnt_q + 16'd1;
  end

  assign reject_cnt_o = reject_cnt_q;

  logic unused_lfsr;
  assign unused_lfsr = ^lfsr;
`else
  logic unused_bits;
  assign unused_bits = ^{lfsr, reject};
`endif

endmodule

// File: tb/tb_lfsr_rng.sv
// Directed bench for lfsr_rng with a queue-based scoreboard per instance.
module tb_lfsr_rng;

  typedef struct {
    logic [3:0] v;
    int         lat;
    int         issue;
  } exp_t;

  logic clk, rst_n;
  logic en_a, sl_a, req_a, busy_a, rv_a;
  logic [3:0] seed_a, lim_a, rand_a;
  logic en_b, sl_b, req_b, busy_b, rv_b;
  logic [3:0] seed_b, lim_b, rand_b;
`ifdef RNG_STATS_EN
  logic [15:0] rc_a, rc_b;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  exp_t qa[$];
  exp_t qb[$];
  exp_t ea, eb;
  logic [3:0] seq [15] = '{4'h1, 4'hC, 4'h6, 4'h3, 4'hD, 4'hA, 4'h5, 4'hE,
                           4'h7, 4'hF, 4'hB, 4'h9, 4'h8, 4'h4, 4'h2};

  lfsr_rng #(.WIDTH(4), .OUT_W(4), .MAX_TRIES(4), .DEFAULT_SEED(1)) u_a (
    .clk(clk), .rst_n(rst_n), .en_i(en_a), .seed_load_i(sl_a), .seed_i(seed_a),
    .req_i(req_a), .limit_i(lim_a), .busy_o(busy_a), .rand_valid_o(rv_a),
    .rand_o(rand_a)
`ifdef RNG_STATS_EN
    , .reject_cnt_o(rc_a)
`endif
  );

  lfsr_rng #(.WIDTH(4), .OUT_W(4), .MAX_TRIES(1), .DEFAULT_SEED(1)) u_b (
    .clk(clk), .rst_n(rst_n), .en_i(en_b), .seed_load_i(sl_b), .seed_i(seed_b),
    .req_i(req_b), .limit_i(lim_b), .busy_o(busy_b), .rand_valid_o(rv_b),
    .rand_o(rand_b)
`ifdef RNG_STATS_EN
    , .reject_cnt_o(rc_b)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  // Monitors: pop expected result whenever a rand_valid pulse appears.
  always @(negedge clk) begin
    if (rst_n && rv_a) begin
      if (qa.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL unexpected_valid_a: got rand=%0h, required no pulse", rand_a);
      end else begin
        ea = qa.pop_front();
        check("rand_a", 32'(rand_a), 32'(ea.v));
        check("latency_a", 32'(cyc - ea.issue + 1), 32'(ea.lat));
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && rv_b) begin
      if (qb.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL unexpected_valid_b: got rand=%0h, required no pulse", rand_b);
      end else begin
        eb = qb.pop_front();
        check("rand_b", 32'(rand_b), 32'(eb.v));
        check("latency_b", 32'(cyc - eb.issue + 1), 32'(eb.lat));
      end
    end
  end

  task automatic wait_done(input bit b);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); #1;
      if ((b ? qb.size() : qa.size()) == 0) return;
    end
    n_cmp++; n_bad++;
    $display("FAIL timeout_%s: got no rand_valid, required one within 20 cycles", b ? "b" : "a");
    if (b) qb.delete(); else qa.delete();
  endtask

  task automatic load(input bit b, input logic [3:0] s);
    @(negedge clk);
    if (b) begin sl_b = 1'b1; seed_b = s; end else begin sl_a = 1'b1; seed_a = s; end
    @(negedge clk);
    if (b) sl_b = 1'b0; else sl_a = 1'b0;
  endtask

  task automatic draw(input bit b, input logic [3:0] lim, input logic [3:0] v, input int lat);
    @(negedge clk);
    if (b) begin
      req_b = 1'b1; lim_b = lim; qb.push_back('{v, lat, cyc + 1});
    end else begin
      req_a = 1'b1; lim_a = lim; qa.push_back('{v, lat, cyc + 1});
    end
    @(negedge clk);
    if (b) req_b = 1'b0; else req_a = 1'b0;
    wait_done(b);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test, required finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    {en_a, sl_a, req_a, seed_a, lim_a} = '0;
    {en_b, sl_b, req_b, seed_b, lim_b} = '0;
    repeat (2) @(negedge clk);
    check("reset_busy", 32'(busy_a), 32'd0);
    check("reset_valid", 32'(rv_a), 32'd0);
    check("reset_rand", 32'(rand_a), 32'd0);
    check("reset_lfsr", 32'(u_a.lfsr), 32'd1);
    rst_n = 1'b1;

    // Full period of the 4-bit sequence.
    load(1'b0, 4'h1);
    check("seq_load", 32'(u_a.lfsr), 32'd1);
    en_a = 1'b1;
    for (int k = 1; k <= 15; k++) begin
      @(negedge clk);
      check("seq_step", 32'(u_a.lfsr), 32'(seq[k % 15]));
    end
    en_a = 1'b0;

    // Draws with limit 5 from seed 1: 1, 4, then 6 rejected -> 3.
    load(1'b0, 4'h1);
    draw(1'b0, 4'd5, 4'h1, 2);
    draw(1'b0, 4'd5, 4'h4, 2);
    draw(1'b0, 4'd5, 4'h3, 3);
    check("lfsr_after_draws", 32'(u_a.lfsr), 32'hD);
    draw(1'b0, 4'd1, 4'h0, 2);

    // Zero seed substitution, then a full-range draw.
    load(1'b0, 4'h0);
    check("zero_seed", 32'(u_a.lfsr), 32'd1);
    draw(1'b0, 4'd0, 4'h1, 2);

    // Limit latched at request; req held through DRAW and DONE is ignored.
    load(1'b0, 4'h6);
    @(negedge clk); req_a = 1'b1; lim_a = 4'd5; qa.push_back('{4'h3, 3, cyc + 1});
    @(negedge clk); lim_a = 4'd0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk); req_a = 1'b0;
    check("busy_after_done", 32'(busy_a), 32'd0);
    @(negedge clk);
    check("busy_idle", 32'(busy_a), 32'd0);
    check("pending_a", 32'(qa.size()), 32'd0);

    // Abort by seed_load while busy, with a simultaneous req.
    load(1'b0, 4'h7);
    @(negedge clk); req_a = 1'b1; lim_a = 4'd5;
    @(negedge clk);
    check("abort_busy_before", 32'(busy_a), 32'd1);
    sl_a = 1'b1; seed_a = 4'h9;
    @(negedge clk); sl_a = 1'b0; req_a = 1'b0;
    check("abort_busy", 32'(busy_a), 32'd0);
    check("abort_valid", 32'(rv_a), 32'd0);
    check("abort_lfsr", 32'(u_a.lfsr), 32'h9);
    @(negedge clk);
    check("abort_busy_after", 32'(busy_a), 32'd0);
    check("abort_valid_after", 32'(rv_a), 32'd0);

    // Asynchronous reset in the middle of a draw.
    load(1'b0, 4'h7);
    @(negedge clk); req_a = 1'b1; lim_a = 4'd5;
    @(negedge clk); req_a = 1'b0;
    @(negedge clk);
    check("mid_draw_busy", 32'(busy_a), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("areset_busy", 32'(busy_a), 32'd0);
    check("areset_valid", 32'(rv_a), 32'd0);
    check("areset_rand", 32'(rand_a), 32'd0);
    check("areset_lfsr", 32'(u_a.lfsr), 32'd1);
`ifdef RNG_STATS_EN
    check("areset_rejects", 32'(rc_a), 32'd0);
`endif
    @(negedge clk); rst_n = 1'b1;

    // Fallback path with MAX_TRIES=1.
    load(1'b1, 4'h6);
    draw(1'b1, 4'd5, 4'h1, 2);
`ifdef RNG_STATS_EN
    check("rejects_1", 32'(rc_b), 32'd1);
`endif
    draw(1'b1, 4'd3, 4'h0, 2);
`ifdef RNG_STATS_EN
    check("rejects_2", 32'(rc_b), 32'd2);
`endif
    draw(1'b1, 4'd0, 4'hD, 2);
    check("lfsr_b", 32'(u_b.lfsr), 32'hA);

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
